// File: rtl/tilt_pkg.sv
// Shared constants and helpers for the tilt-to-step rate generator.
package tilt_pkg;

    // Bit positions inside move_pulses
    localparam int X_NEG = 0;
    localparam int X_POS = 1;
    localparam int Y_NEG = 2;
    localparam int Y_POS = 3;

    // Width of a speed-level field; never narrower than one bit
    function automatic int level_w(input int num_levels);
        return (num_levels > 1) ? $clog2(num_levels) : 1;
    endfunction

    // Step period in clocks for a speed level: base halved per level, floored at 1
    function automatic longint unsigned period_for_level(input longint unsigned base,
                                                         input int level);
        longint unsigned p;
        p = base >> level;
        return (p == 64'd0) ? 64'd1 : p;
    endfunction

    // Convert a raw sample to a sign-extended signed value centred on zero
    function automatic logic signed [31:0] centre_sample(input logic [31:0] data,
                                                         input int data_w,
                                                         input bit offset_binary);
        logic [31:0] mask;
        logic [31:0] msb;
        logic [31:0] v;
        mask = (data_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << data_w) - 32'd1);
        msb  = 32'd1 << (data_w - 1);
        v    = data & mask;
        if (offset_binary) begin
            v = v ^ msb;
        end
        if ((v & msb) != 32'd0) begin
            v = v | ~mask;
        end
        return signed'(v);
    endfunction

    // Magnitude of a centred value; the most-negative code clips to the positive maximum
    function automatic logic [31:0] sat_mag(input logic signed [31:0] c, input int data_w);
        logic [31:0] lim;
        logic [31:0] m;
        lim = (32'd1 << (data_w - 1)) - 32'd1;
        m   = (c < 0) ? unsigned'(-c) : unsigned'(c);
        return (m > lim) ? lim : m;
    endfunction

endpackage

// File: rtl/tilt_axis_rate.sv
// One tilt axis: classification register, rate counter and step pulse register.
module tilt_axis_rate
    import tilt_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int DATA_W           = 8,
    parameter int OFFSET_BINARY    = 1,
    parameter int DEADZONE         = 16,
    parameter int LEVEL_SHIFT      = 4,
    parameter int NUM_LEVELS       = 8,
    parameter int MIN_RATE_HZ      = 16,
    parameter int CNTR_WIDTH       = 32,
    parameter int SIMULATE         = 0,
    parameter int SIMULATE_PERIOD  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             sample_p1,
    input  logic [1:0]                    blocked,
    output logic [1:0]                    pulses,
    output logic                          active,
    output logic [level_w(NUM_LEVELS)-1:0] level
);

    localparam int LVL_W = level_w(NUM_LEVELS);
    localparam longint unsigned BASE = (SIMULATE != 0)
        ? (64'(SIMULATE_PERIOD) << (NUM_LEVELS - 1))
        : 64'(CLK_FREQUENCY_HZ / MIN_RATE_HZ);

    logic signed [31:0] cen_s;
    logic [31:0]        mag_s;
    logic [31:0]        over_s;
    logic [31:0]        lvl_raw_s;
    logic               act_s;
    logic               neg_s;
    logic [LVL_W-1:0]   lvl_s;

    // Classify the held sample: centre, magnitude, dead zone, speed level, direction
    always_comb begin
        cen_s     = centre_sample(32'(sample_p1), DATA_W, OFFSET_BINARY != 0);
        mag_s     = sat_mag(cen_s, DATA_W);
        act_s     = mag_s > 32'(DEADZONE);
        neg_s     = cen_s < 0;
        over_s    = act_s ? (mag_s - 32'(DEADZONE) - 32'd1) : 32'd0;
        lvl_raw_s = over_s >> LEVEL_SHIFT;
        lvl_s     = (lvl_raw_s > 32'(NUM_LEVELS - 1)) ? LVL_W'(NUM_LEVELS - 1)
                                                      : LVL_W'(lvl_raw_s);
    end

    // ---- stage 2: classification register ----
    logic             act_p2;
    logic             neg_p2;
    logic             restart_p2;
    logic             lvl_up_p2;
    logic [LVL_W-1:0] lvl_p2;

    // Register classification; flag restarts (new activity or reversal) and level rises
    always_ff @(posedge clk) begin
        if (reset) begin
            act_p2     <= 1'b0;
            neg_p2     <= 1'b0;
            restart_p2 <= 1'b0;
            lvl_up_p2  <= 1'b0;
            lvl_p2     <= '0;
        end else begin
            act_p2     <= act_s;
            neg_p2     <= neg_s;
            lvl_p2     <= lvl_s;
            restart_p2 <= act_s && (!act_p2 || (neg_s != neg_p2));
            lvl_up_p2  <= act_s && act_p2 && (lvl_s > lvl_p2);
        end
    end

    // ---- stage 3: rate counter and step pulse ----
    logic [CNTR_WIDTH-1:0] reload;
    logic [CNTR_WIDTH-1:0] cnt_p3;
    logic [1:0]            pulse_p3;

    // Counter reload value for the current level
    always_comb begin
        reload = CNTR_WIDTH'(period_for_level(BASE, int'(lvl_p2)) - 64'd1);
    end

    // Count down to zero, emit one step per period; reload on idle, disable or restart.
    // A faster level cuts a long remaining count short; a slower level lets it run out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p3   <= '0;
            pulse_p3 <= 2'b00;
        end else begin
            pulse_p3 <= 2'b00;
            if (!act_p2 || !enable || restart_p2) begin
                cnt_p3 <= reload;
            end else if (cnt_p3 == '0) begin
                cnt_p3 <= reload;
                if (neg_p2) begin
                    pulse_p3[0] <= !blocked[0];
                end else begin
                    pulse_p3[1] <= !blocked[1];
                end
            end else if (lvl_up_p2 && (cnt_p3 > reload)) begin
                cnt_p3 <= reload;
            end else begin
                cnt_p3 <= cnt_p3 - CNTR_WIDTH'(1);
            end
        end
    end

    assign pulses = pulse_p3;
    assign active = act_p2;
    assign level  = lvl_p2;

endmodule

// File: rtl/tilt_step_gen.sv
// Tilt-to-step rate generator: shared sample capture feeding one rate engine per axis.
module tilt_step_gen
    import tilt_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int NUM_AXES         = 2,
    parameter int DATA_W           = 8,
    parameter int OFFSET_BINARY    = 1,
    parameter int DEADZONE         = 16,
    parameter int LEVEL_SHIFT      = 4,
    parameter int NUM_LEVELS       = 8,
    parameter int MIN_RATE_HZ      = 16,
    parameter int CNTR_WIDTH       = 32,
    parameter int SIMULATE         = 0,
    parameter int SIMULATE_PERIOD  = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   accel_valid,
    input  logic [NUM_AXES*DATA_W-1:0]             accel_data,
    input  logic [2*NUM_AXES-1:0]                  blocked,
    output logic [2*NUM_AXES-1:0]                  move_pulses,
    output logic [NUM_AXES-1:0]                    axis_active,
    output logic [NUM_AXES*level_w(NUM_LEVELS)-1:0] axis_level
);

    localparam int LVL_W = level_w(NUM_LEVELS);
    localparam logic [DATA_W-1:0] CENTRE = (OFFSET_BINARY != 0)
        ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    // ---- stage 1: sample capture ----
    logic [NUM_AXES*DATA_W-1:0] sample_p1;

    // Capture all axes together on each valid strobe and hold between strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_p1 <= {NUM_AXES{CENTRE}};
        end else if (accel_valid) begin
            sample_p1 <= accel_data;
        end
    end

    // ---- stage 2 onwards: independent per-axis rate engines ----
    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        tilt_axis_rate #(
            .CLK_FREQUENCY_HZ (CLK_FREQUENCY_HZ),
            .DATA_W           (DATA_W),
            .OFFSET_BINARY    (OFFSET_BINARY),
            .DEADZONE         (DEADZONE),
            .LEVEL_SHIFT      (LEVEL_SHIFT),
            .NUM_LEVELS       (NUM_LEVELS),
            .MIN_RATE_HZ      (MIN_RATE_HZ),
            .CNTR_WIDTH       (CNTR_WIDTH),
            .SIMULATE         (SIMULATE),
            .SIMULATE_PERIOD  (SIMULATE_PERIOD)
        ) u_axis (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .sample_p1 (sample_p1[a*DATA_W +: DATA_W]),
            .blocked   (blocked[2*a +: 2]),
            .pulses    (move_pulses[2*a +: 2]),
            .active    (axis_active[a]),
            .level     (axis_level[a*LVL_W +: LVL_W])
        );
    end

endmodule
